// File: rtl/fpu_pkg.sv
// Shared FPU result field widths, status bit positions and the queued result payload.
package fpu_pkg;

    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXP_W  = 7;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned WORD_W = SIGN_W + EXP_W + MANT_W;
    localparam int unsigned STAT_W = 4;

    localparam int unsigned ST_EXACT   = 0;
    localparam int unsigned ST_OVF     = 1;
    localparam int unsigned ST_UDF     = 2;
    localparam int unsigned ST_INEXACT = 3;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [STAT_W-1:0] status;
    } fpu_result_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear coinciding with an increment restarts the count at one.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fpu_result_queue.sv
// Capture FIFO behind the non-stallable FPU, with sticky status, event counters and overrun flag.
module fpu_result_queue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WORD_W-1:0]       in_data,
    input  logic [STAT_W-1:0]       in_status,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W-1:0]       out_data,
    output logic [STAT_W-1:0]       out_status,
    output logic [STAT_W-1:0]       sticky_status,
    output logic [CNT_W-1:0]        ovf_count,
    output logic [CNT_W-1:0]        udf_count,
    output logic                    overrun,
    input  logic                    clr,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    fpu_result_t        mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [STAT_W-1:0]  sticky_q, sticky_d;
    logic               overrun_q, overrun_d;
    logic               push, pop, drop;
    fpu_result_t        head;

    // Full/empty come from the occupancy count; there is no pass-through when full.
    assign in_ready  = level_q < LVL_W'(DEPTH);
    assign out_valid = level_q != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign drop      = in_valid & ~in_ready;

    assign head       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_data   = head.word;
    assign out_status = head.status;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        sticky_d  = sticky_q;
        overrun_d = overrun_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (clr) begin
            sticky_d = push ? in_status : '0;
        end else if (push) begin
            sticky_d = sticky_q | in_status;
        end

        // A drop in the same cycle as a clear still records the overrun.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            sticky_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            sticky_q  <= sticky_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{word: in_data, status: in_status};
    end

    sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (push & in_status[ST_OVF]),
        .clr_i   (clr),
        .count_o (ovf_count)
    );

    sat_counter #(.W(CNT_W)) u_udf_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (push & in_status[ST_UDF]),
        .clr_i   (clr),
        .count_o (udf_count)
    );

    assign level         = level_q;
    assign sticky_status = sticky_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_fpu_result_queue.sv
// Directed bench for fpu_result_queue with DEPTH=4 and 2-bit counters.
module tb_fpu_result_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_status;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_status;
    logic [3:0]  sticky_status;
    logic [1:0]  ovf_count;
    logic [1:0]  udf_count;
    logic        overrun;
    logic        clr;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    fpu_result_queue #(.DEPTH(4), .CNT_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_status     (in_status),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_status    (out_status),
        .sticky_status (sticky_status),
        .ovf_count     (ovf_count),
        .udf_count     (udf_count),
        .overrun       (overrun),
        .clr           (clr),
        .level         (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_status = '0;
        out_ready = 1'b0; clr = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();

        // Reset then idle
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_data",  out_data,        32'd0);
        check("idle_in_ready",  32'(in_ready),  32'd1);
        check("idle_level",     32'(level),     32'd0);
        check("idle_sticky",    32'(sticky_status), 32'd0);
        check("idle_ovf",       32'(ovf_count), 32'd0);
        check("idle_udf",       32'(udf_count), 32'd0);
        check("idle_overrun",   32'(overrun),   32'd0);

        // Single result, visible one cycle later
        in_valid = 1'b1; in_data = 32'h3F800000; in_status = 4'b0001;
        step();
        in_valid = 1'b0; in_status = 4'b0000;
        check("single_valid",  32'(out_valid),     32'd1);
        check("single_data",   out_data,            32'h3F800000);
        check("single_status", 32'(out_status),    32'h1);
        check("single_level",  32'(level),         32'd1);
        check("single_sticky", 32'(sticky_status), 32'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_drained", 32'(level), 32'd0);

        // Fill to DEPTH, then overrun
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            step();
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level",    32'(level),    32'd4);
        check("full_no_ovr",   32'(overrun),  32'd0);
        in_data = 32'd5;
        step();
        in_valid = 1'b0;
        check("ovr_flag",  32'(overrun), 32'd1);
        check("ovr_level", 32'(level),   32'd4);
        check("ovr_head",  out_data,     32'd1);

        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_ovr", 32'(overrun), 32'd0);

        clr = 1'b1; in_valid = 1'b1; in_data = 32'h66;
        step();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_drop_ovr",   32'(overrun), 32'd1);
        check("clr_drop_level", 32'(level),   32'd4);

        // Pop while full: the simultaneous push is still dropped
        in_valid = 1'b1; in_data = 32'd7; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("nopass_level", 32'(level), 32'd3);
        check("nopass_head",  out_data,   32'd2);

        out_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("drain_%0d", i), out_data, 32'(i));
            step();
        end
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data",  out_data,       32'd0);

        // Simultaneous push/pop at level 2 across pointer wrap
        in_valid = 1'b1; in_data = 32'h100;
        step();
        in_data = 32'h101;
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 32'h102 + 32'(k);
            check($sformatf("pp_head_%0d", k), out_data, 32'h100 + 32'(k));
            step();
            check($sformatf("pp_level_%0d", k), 32'(level), 32'd2);
        end
        in_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            check($sformatf("pp_tail_%0d", k), out_data, 32'h100 + 32'(k));
            step();
        end
        out_ready = 1'b0;
        check("pp_empty", 32'(level), 32'd0);

        // Counter saturation at 3
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("sat_clr_ovf", 32'(ovf_count), 32'd0);
        in_valid = 1'b1; in_status = 4'b0110; in_data = 32'hABCD; out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("sat_ovf_%0d", k), 32'(ovf_count), (k > 3) ? 32'd3 : 32'(k));
        end
        in_valid = 1'b0;
        check("sat_udf",     32'(udf_count),     32'd3);
        check("sat_sticky",  32'(sticky_status), 32'h6);
        check("sat_overrun", 32'(overrun),       32'd0);
        step();
        out_ready = 1'b0;
        check("sat_empty", 32'(level), 32'd0);

        // clr with a push loads the new status rather than clearing
        in_valid = 1'b1; in_status = 4'b1000;
        step();
        check("cp_sticky_pre", 32'(sticky_status), 32'hE);
        clr = 1'b1; in_status = 4'b0001;
        step();
        check("cp_sticky", 32'(sticky_status), 32'h1);
        check("cp_ovf",    32'(ovf_count),     32'd0);
        check("cp_udf",    32'(udf_count),     32'd0);
        check("cp_ovr",    32'(overrun),       32'd0);
        in_status = 4'b0110;
        step();
        clr = 1'b0; in_valid = 1'b0; in_status = 4'b0000;
        check("cp2_ovf",    32'(ovf_count),     32'd1);
        check("cp2_udf",    32'(udf_count),     32'd1);
        check("cp2_sticky", 32'(sticky_status), 32'h6);
        check("cp2_level",  32'(level),         32'd3);

        // Mid-run asynchronous reset
        #2;
        rst = 1'b0;
        #1;
        check("mr_valid",  32'(out_valid), 32'd0);
        check("mr_level",  32'(level),     32'd0);
        check("mr_data",   out_data,       32'd0);
        check("mr_ovf",    32'(ovf_count), 32'd0);
        check("mr_ready",  32'(in_ready),  32'd1);
        rst = 1'b1;
        step();
        check("post_rst_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
